sfo_fft_correlator_multi: RTL and testbench
===========================================

SFO_FFT_CORRELATOR_MULTI -- requirements
Module: sfo_fft_correlator_multi

Interface
REQ-001 SHALL have parameter FFT_LEN_LOG2, default 9, meaning log2 of the FFT bins per frame.
REQ-002 SHALL have parameter POWER_WIDTH, default 16, meaning the magnitude width.
REQ-003 SHALL have parameter NUM_HYP, default 4, meaning the SFO hypotheses evaluated in parallel; HYP_LOG2, default 2, is its index width.
REQ-004 SHALL have parameters SFO_INT_WIDTH, default 9, and SFO_FRAC_WIDTH, default 16, meaning the spacing fixed-point format.
REQ-005 SHALL have parameter NUM_HARMONICS_LOG2, default 5, and SKIRT_WIDTH, default 2, meaning the guard bins each side of a harmonic.
REQ-006 SHALL have parameters OUT_FRAC_BITS, default 13, meaning quotient fraction bits, and CORR_WIDTH, default 26, meaning output width.
REQ-007 clk  in  1  clock; all logic on its rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 start  in  1  one-cycle pulse that latches settings and begins a frame.
REQ-010 sfo_int_base / sfo_frac_base  in  SFO_INT_WIDTH / SFO_FRAC_WIDTH  spacing of hypothesis 0.
REQ-011 sfo_int_step / sfo_frac_step  in  SFO_INT_WIDTH / SFO_FRAC_WIDTH  spacing increment per hypothesis index.
REQ-012 setting_num_harmonics  in  NUM_HARMONICS_LOG2  harmonics summed per hypothesis.
REQ-013 fft_mag_in, fft_valid, fft_last  in  POWER_WIDTH, 1, 1  bin stream; fft_ready  out  1.
REQ-014 corr_out  out  CORR_WIDTH; corr_hyp_index  out  HYP_LOG2; metadata_out  out  2*(POWER_WIDTH+FFT_LEN_LOG2) {num,den}.
REQ-015 corr_valid  out  1; corr_ready  in  1  result handshake.
REQ-016 best_index  out  HYP_LOG2; best_corr  out  CORR_WIDTH; best_valid  out  1; busy  out  1.

Function
REQ-017 SHALL implement states IDLE, INIT, ACCUM, DIVIDE, OUTPUT; start in any state aborts current work and enters INIT.
REQ-018 INIT SHALL take NUM_HYP cycles computing spacing_k = base + k*step (int.frac) and first-harmonic position by accumulation, then enter ACCUM.
REQ-019 Harmonic m of hypothesis k SHALL sit at bin floor(m*spacing_k + 0.5), exact in fixed point (frac accumulator seeded with one half).
REQ-020 fft_ready SHALL be 1 only in ACCUM; a bin is consumed when fft_valid & fft_ready; bin index starts at 0 per frame.
REQ-021 Per consumed bin, each hypothesis with harmonic count < setting_num_harmonics SHALL add magnitude to numerator if index equals its next harmonic.
REQ-022 Otherwise it SHALL add to denominator iff index != 0, index > last_harmonic + SKIRT_WIDTH (last_harmonic initially 0) and index < next_harmonic - SKIRT_WIDTH.
REQ-023 Numerator and denominator SHALL be POWER_WIDTH+FFT_LEN_LOG2 bits, non-saturating by construction.
REQ-024 ACCUM SHALL end after the bin with fft_last or bin index 2^FFT_LEN_LOG2-1, whichever first; index never wraps.
REQ-025 DIVIDE SHALL compute floor((num << OUT_FRAC_BITS) / max(den,1)) with a shared one-bit-per-cycle restoring divider, hypotheses in order 0..NUM_HYP-1.
REQ-026 Quotient exceeding 2^CORR_WIDTH-1 SHALL saturate to all ones.
REQ-027 Each quotient SHALL go to OUTPUT: corr_valid held with stable corr_out, corr_hyp_index, metadata_out until corr_ready; transfer on valid&ready, then next DIVIDE or IDLE after last.
REQ-028 Best tracking SHALL replace on strictly greater quotient only (ties keep lower index); best_valid SHALL pulse one cycle with the final transfer.
REQ-029 busy SHALL be 1 in every state except IDLE.
REQ-030 setting_num_harmonics = 0 SHALL yield num = den = 0 and quotient 0 for all hypotheses.

Reset
REQ-031 On reset all state SHALL go to IDLE; fft_ready, corr_valid, best_valid, busy = 0; corr_out, best_corr, best_index, metadata_out, accumulators = 0.
REQ-032 Reset mid-frame SHALL discard all partial results; no corr_valid until a new start.

Verification
REQ-033 Params FFT_LEN_LOG2=6, NUM_HYP=2, SKIRT_WIDTH=2, OUT_FRAC_BITS=8; base 8.0, step 0.5, harmonics 3; mag 100 at bins 8,16,24, 1 elsewhere, 64 bins -> hyp0 num 300 den 9 corr 8533; hyp1 num 3 den 11 corr 69; best_index 0.
REQ-034 Same frame with corr_ready low 20 cycles on first result -> corr_out and metadata_out stable, no second result until accepted.
REQ-035 All magnitudes 0 -> den 0 treated as 1, every corr_out 0, best_index 0.
REQ-036 fft_last on bin 10 with base 4.0, harmonics 5 -> accumulation stops after bin 10; hyp0 num counts bins 4 and 8 only.
REQ-037 Assert reset at bin 30 of a frame, then start new frame -> only new-frame results appear, values match REQ-033.
REQ-038 Numerator 2^22 with den 1, CORR_WIDTH=20 -> corr_out saturates to 0xFFFFF.

Source files
------------

// File: rtl/sfo_fft_correlator_multi_if.sv
// Bundles the correlator settings, the FFT bin stream and the result/best outputs.
// Handshake rule for both streams: a beat transfers on a rising clk edge where
// valid and ready are both 1; the source holds valid and its data stable until
// that edge, while ready may rise or fall at any cycle.
interface sfo_fft_correlator_multi_if #(
  parameter int FFT_LEN_LOG2       = 9,
  parameter int POWER_WIDTH        = 16,
  parameter int HYP_LOG2           = 2,
  parameter int SFO_INT_WIDTH      = 9,
  parameter int SFO_FRAC_WIDTH     = 16,
  parameter int NUM_HARMONICS_LOG2 = 5,
  parameter int CORR_WIDTH         = 26
);
  localparam int ACC_WIDTH = POWER_WIDTH + FFT_LEN_LOG2;

  logic                          start;
  logic [SFO_INT_WIDTH-1:0]      sfo_int_base;
  logic [SFO_FRAC_WIDTH-1:0]     sfo_frac_base;
  logic [SFO_INT_WIDTH-1:0]      sfo_int_step;
  logic [SFO_FRAC_WIDTH-1:0]     sfo_frac_step;
  logic [NUM_HARMONICS_LOG2-1:0] setting_num_harmonics;
  logic [POWER_WIDTH-1:0]        fft_mag_in;
  logic                          fft_valid;
  logic                          fft_last;
  logic                          fft_ready;
  logic [CORR_WIDTH-1:0]         corr_out;
  logic [HYP_LOG2-1:0]           corr_hyp_index;
  logic [2*ACC_WIDTH-1:0]        metadata_out;
  logic                          corr_valid;
  logic                          corr_ready;
  logic [HYP_LOG2-1:0]           best_index;
  logic [CORR_WIDTH-1:0]         best_corr;
  logic                          best_valid;
  logic                          busy;
  logic [2:0]                    state_dbg;

  modport master (
    output start, sfo_int_base, sfo_frac_base, sfo_int_step, sfo_frac_step,
           setting_num_harmonics, fft_mag_in, fft_valid, fft_last, corr_ready,
    input  fft_ready, corr_out, corr_hyp_index, metadata_out, corr_valid,
           best_index, best_corr, best_valid, busy, state_dbg
  );

  modport slave (
    input  start, sfo_int_base, sfo_frac_base, sfo_int_step, sfo_frac_step,
           setting_num_harmonics, fft_mag_in, fft_valid, fft_last, corr_ready,
    output fft_ready, corr_out, corr_hyp_index, metadata_out, corr_valid,
           best_index, best_corr, best_valid, busy, state_dbg
  );
endinterface

// File: rtl/sfo_fft_correlator_multi.sv
// Harmonic-comb correlator: for several sampling-frequency-offset hypotheses it
// sums FFT power on the expected harmonic bins (numerator) and on the quiet bins
// between them (denominator), then reports num/den per hypothesis and the best one.
module sfo_fft_correlator_multi #(
  parameter int FFT_LEN_LOG2       = 9,
  parameter int POWER_WIDTH        = 16,
  parameter int NUM_HYP            = 4,
  parameter int HYP_LOG2           = 2,
  parameter int SFO_INT_WIDTH      = 9,
  parameter int SFO_FRAC_WIDTH     = 16,
  parameter int NUM_HARMONICS_LOG2 = 5,
  parameter int SKIRT_WIDTH        = 2,
  parameter int OUT_FRAC_BITS      = 13,
  parameter int CORR_WIDTH         = 26
) (
  input logic clk,
  input logic reset,
  sfo_fft_correlator_multi_if.slave bus
);
  localparam int AW  = POWER_WIDTH + FFT_LEN_LOG2;          // accumulator width
  localparam int DW  = AW + OUT_FRAC_BITS;                  // dividend/quotient width
  localparam int SIW = SFO_INT_WIDTH + HYP_LOG2 + 1;        // spacing integer bits (base + k*step)
  localparam int SW  = SIW + SFO_FRAC_WIDTH;
  localparam int PIW = SIW + NUM_HARMONICS_LOG2 + 1;        // harmonic position integer bits
  localparam int PW  = PIW + SFO_FRAC_WIDTH;
  localparam int CW  = PIW + 1;                             // bin comparison width, room for +skirt
  localparam int DCW = $clog2(DW + 1);
  localparam logic [PW-1:0] HALF    = PW'(1) << (SFO_FRAC_WIDTH - 1);
  localparam logic [CW-1:0] SKIRT_C = CW'(SKIRT_WIDTH);

  typedef enum logic [2:0] {IDLE = 3'd0, INIT = 3'd1, ACCUM = 3'd2, DIVIDE = 3'd3, OUTPUT = 3'd4} state_t;
  state_t state, state_nxt;

  logic [SW-1:0]                 step_q, sp_acc;
  logic [NUM_HARMONICS_LOG2-1:0] nh_q;
  logic [HYP_LOG2-1:0]           hk, dk;
  logic [FFT_LEN_LOG2-1:0]       idx;
  logic [SW-1:0]                 spacing [NUM_HYP];
  logic [PW-1:0]                 pos     [NUM_HYP];
  logic [NUM_HARMONICS_LOG2-1:0] cnt     [NUM_HYP];
  logic [FFT_LEN_LOG2-1:0]       last_h  [NUM_HYP];
  logic [AW-1:0]                 num     [NUM_HYP];
  logic [AW-1:0]                 den     [NUM_HYP];
  logic [AW-1:0]                 rem;
  logic [DW-1:0]                 quo;
  logic [DCW-1:0]                dcnt;
  logic [CORR_WIDTH-1:0]         corr_q, best_corr_q;
  logic [HYP_LOG2-1:0]           corr_idx_q, best_idx_q;
  logic [2*AW-1:0]               meta_q;

  logic                          init_done, bin_end, div_done, out_take, last_hyp;
  logic [CW-1:0]                 idx_c;
  logic [CW-1:0]                 harm [NUM_HYP];
  logic [NUM_HYP-1:0]            hit, skirt;
  logic [AW-1:0]                 mag_ext, divisor, rem_nxt;
  logic [AW:0]                   trial;
  logic [DW-1:0]                 quo_nxt;
  logic [CORR_WIDTH-1:0]         corr_res;
  logic                          fft_ready_c, corr_valid_c, best_valid_c, busy_c;

  assign last_hyp  = (dk == HYP_LOG2'(NUM_HYP - 1));
  assign init_done = (state == INIT) && (hk == HYP_LOG2'(NUM_HYP - 1));
  assign bin_end   = (state == ACCUM) && bus.fft_valid && (bus.fft_last || (idx == '1));
  assign div_done  = (state == DIVIDE) && (dcnt == DCW'(DW));
  assign out_take  = (state == OUTPUT) && bus.corr_ready;
  assign idx_c     = CW'(idx);
  assign mag_ext   = AW'(bus.fft_mag_in);

  // Classify the current bin per hypothesis: harmonic hit, skirt-free noise bin, or ignored.
  always_comb begin
    hit   = '0;
    skirt = '0;
    for (int k = 0; k < NUM_HYP; k++) begin
      harm[k]  = {1'b0, pos[k][PW-1:SFO_FRAC_WIDTH]};
      hit[k]   = (cnt[k] < nh_q) && (idx_c == harm[k]);
      skirt[k] = (cnt[k] < nh_q) && !hit[k] && (idx != '0) &&
                 (idx_c > CW'(last_h[k]) + SKIRT_C) && (idx_c + SKIRT_C < harm[k]);
    end
  end

  // One restoring-division step on the selected hypothesis, plus output saturation.
  always_comb begin
    divisor = (den[dk] == '0) ? AW'(1) : den[dk];
    trial   = {rem, quo[DW-1]};
    if (trial >= {1'b0, divisor}) begin
      rem_nxt = AW'(trial - {1'b0, divisor});
      quo_nxt = {quo[DW-2:0], 1'b1};
    end else begin
      rem_nxt = trial[AW-1:0];
      quo_nxt = {quo[DW-2:0], 1'b0};
    end
    corr_res = ((quo_nxt >> CORR_WIDTH) != '0) ? '1 : CORR_WIDTH'(quo_nxt);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; start overrides everything and restarts the frame.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = IDLE;
      INIT:    if (init_done) state_nxt = ACCUM;
      ACCUM:   if (bin_end)   state_nxt = DIVIDE;
      DIVIDE:  if (div_done)  state_nxt = OUTPUT;
      OUTPUT:  if (out_take)  state_nxt = last_hyp ? IDLE : DIVIDE;
      default: state_nxt = IDLE;
    endcase
    if (bus.start) state_nxt = INIT;
  end

  // FSM outputs; bins are refused in a start cycle because that cycle discards them.
  always_comb begin
    fft_ready_c  = (state == ACCUM) && !bus.start;
    corr_valid_c = (state == OUTPUT);
    best_valid_c = out_take && last_hyp && !bus.start;
    busy_c       = (state != IDLE);
  end

  // Datapath: settings latch, spacing setup, accumulation, division and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q <= '0; sp_acc <= '0; nh_q <= '0; hk <= '0; dk <= '0; idx <= '0;
      rem <= '0; quo <= '0; dcnt <= '0;
      corr_q <= '0; best_corr_q <= '0; corr_idx_q <= '0; best_idx_q <= '0; meta_q <= '0;
      for (int k = 0; k < NUM_HYP; k++) begin
        spacing[k] <= '0; pos[k] <= '0; cnt[k] <= '0; last_h[k] <= '0; num[k] <= '0; den[k] <= '0;
      end
    end else if (bus.start) begin
      sp_acc <= {{(SIW - SFO_INT_WIDTH){1'b0}}, bus.sfo_int_base, bus.sfo_frac_base};
      step_q <= {{(SIW - SFO_INT_WIDTH){1'b0}}, bus.sfo_int_step, bus.sfo_frac_step};
      nh_q   <= bus.setting_num_harmonics;
      hk <= '0; dk <= '0; idx <= '0; dcnt <= '0;
      best_corr_q <= '0; best_idx_q <= '0;
      for (int k = 0; k < NUM_HYP; k++) begin
        cnt[k] <= '0; last_h[k] <= '0; num[k] <= '0; den[k] <= '0;
      end
    end else begin
      case (state)
        INIT: begin
          spacing[hk] <= sp_acc;
          pos[hk]     <= PW'(sp_acc) + HALF;
          sp_acc      <= sp_acc + step_q;
          hk          <= hk + HYP_LOG2'(1);
        end
        ACCUM: if (bus.fft_valid) begin
          for (int k = 0; k < NUM_HYP; k++) begin
            if (hit[k]) begin
              num[k]    <= num[k] + mag_ext;
              cnt[k]    <= cnt[k] + NUM_HARMONICS_LOG2'(1);
              last_h[k] <= idx;
              pos[k]    <= pos[k] + PW'(spacing[k]);
            end else if (skirt[k]) begin
              den[k] <= den[k] + mag_ext;
            end
          end
          if (idx != '1) idx <= idx + FFT_LEN_LOG2'(1);
        end
        DIVIDE: begin
          if (dcnt == '0) begin
            quo  <= {num[dk], {OUT_FRAC_BITS{1'b0}}};
            rem  <= '0;
            dcnt <= DCW'(1);
          end else begin
            quo <= quo_nxt;
            rem <= rem_nxt;
            if (div_done) begin
              dcnt       <= '0;
              corr_q     <= corr_res;
              corr_idx_q <= dk;
              meta_q     <= {num[dk], den[dk]};
              if (corr_res > best_corr_q) begin
                best_corr_q <= corr_res;
                best_idx_q  <= dk;
              end
            end else begin
              dcnt <= dcnt + DCW'(1);
            end
          end
        end
        OUTPUT: if (out_take && !last_hyp) dk <= dk + HYP_LOG2'(1);
        default: ;
      endcase
    end
  end

  assign bus.fft_ready      = fft_ready_c;
  assign bus.corr_valid     = corr_valid_c;
  assign bus.best_valid     = best_valid_c;
  assign bus.busy           = busy_c;
  assign bus.corr_out       = corr_q;
  assign bus.corr_hyp_index = corr_idx_q;
  assign bus.metadata_out   = meta_q;
  assign bus.best_index     = best_idx_q;
  assign bus.best_corr      = best_corr_q;
  assign bus.state_dbg      = state;
endmodule

// File: tb/tb_sfo_fft_correlator_multi.sv
// Bench for the harmonic-comb correlator: hand-derived frame table, multi-cycle
// corner sequences (back-pressure, reset and start abort) and random frames
// checked against a rule-level model of the correlator.
module tb_sfo_fft_correlator_multi;
  localparam int FFT_LEN_LOG2       = 6;
  localparam int POWER_WIDTH        = 16;
  localparam int NUM_HYP            = 2;
  localparam int HYP_LOG2           = 1;
  localparam int SFO_INT_WIDTH      = 9;
  localparam int SFO_FRAC_WIDTH     = 16;
  localparam int NUM_HARMONICS_LOG2 = 5;
  localparam int SKIRT_WIDTH        = 2;
  localparam int OUT_FRAC_BITS      = 8;
  localparam int CORR_WIDTH         = 20;
  localparam int NBINS              = 1 << FFT_LEN_LOG2;
  localparam int AW                 = POWER_WIDTH + FFT_LEN_LOG2;

  // Clock and reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sfo_fft_correlator_multi_if #(
    .FFT_LEN_LOG2(FFT_LEN_LOG2), .POWER_WIDTH(POWER_WIDTH), .HYP_LOG2(HYP_LOG2),
    .SFO_INT_WIDTH(SFO_INT_WIDTH), .SFO_FRAC_WIDTH(SFO_FRAC_WIDTH),
    .NUM_HARMONICS_LOG2(NUM_HARMONICS_LOG2), .CORR_WIDTH(CORR_WIDTH)
  ) bus ();

  sfo_fft_correlator_multi #(
    .FFT_LEN_LOG2(FFT_LEN_LOG2), .POWER_WIDTH(POWER_WIDTH), .NUM_HYP(NUM_HYP), .HYP_LOG2(HYP_LOG2),
    .SFO_INT_WIDTH(SFO_INT_WIDTH), .SFO_FRAC_WIDTH(SFO_FRAC_WIDTH),
    .NUM_HARMONICS_LOG2(NUM_HARMONICS_LOG2), .SKIRT_WIDTH(SKIRT_WIDTH),
    .OUT_FRAC_BITS(OUT_FRAC_BITS), .CORR_WIDTH(CORR_WIDTH)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  logic [POWER_WIDTH-1:0] mag_arr [NBINS];

  typedef struct {
    logic [CORR_WIDTH-1:0] corr;
    logic [HYP_LOG2-1:0]   idx;
    logic [2*AW-1:0]       meta;
    logic                  bv;
  } res_t;
  res_t got [NUM_HYP];

  // Scoreboard: expected quotients in hypothesis order, plus num/den and best
  logic [CORR_WIDTH-1:0] exp_q [$];
  longint exp_num [NUM_HYP];
  longint exp_den [NUM_HYP];
  longint exp_best_idx;
  longint exp_best_corr;

  typedef struct {
    int bi, bf, si, sf, nh, pat, last_bin, stall;
    longint corr0, corr1, num0, den0, num1, den1;
    int best;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},        64'(bus.busy), 64'd0);
    check({tag, "_fft_ready"},   64'(bus.fft_ready), 64'd0);
    check({tag, "_corr_valid"},  64'(bus.corr_valid), 64'd0);
    check({tag, "_best_valid"},  64'(bus.best_valid), 64'd0);
    check({tag, "_corr_out"},    64'(bus.corr_out), 64'd0);
    check({tag, "_best_corr"},   64'(bus.best_corr), 64'd0);
    check({tag, "_best_index"},  64'(bus.best_index), 64'd0);
    check({tag, "_metadata"},    64'(bus.metadata_out), 64'd0);
  endtask

  task automatic fill_pattern(input int pat);
    for (int b = 0; b < NBINS; b++) begin
      case (pat)
        0: mag_arr[b] = (b == 8 || b == 16 || b == 24) ? 16'd100 : 16'd1;
        1: mag_arr[b] = 16'd0;
        2: mag_arr[b] = (b == 8 || b == 16 || b == 24) ? 16'hFFFF : 16'd0;
        default: mag_arr[b] = (b == 9 || b == 17 || b == 26) ? 16'd100 : 16'd1;
      endcase
    end
  endtask

  // Driver: start a frame, stream bins 0..last_bin (optionally stopping after
  // abort_at bins), then collect NUM_HYP results with optional back-pressure.
  task automatic run_frame(input int bi, input int bf, input int si, input int sf, input int nh,
                           input int last_bin, input int stall, input bit gaps, input int abort_at);
    int i;
    int guard;
    bit take;
    bit stable;
    logic [CORR_WIDTH-1:0] snap_corr;
    logic [2*AW-1:0]       snap_meta;
    logic [HYP_LOG2-1:0]   snap_idx;
    @(negedge clk);
    bus.sfo_int_base          = SFO_INT_WIDTH'(bi);
    bus.sfo_frac_base         = SFO_FRAC_WIDTH'(bf);
    bus.sfo_int_step          = SFO_INT_WIDTH'(si);
    bus.sfo_frac_step         = SFO_FRAC_WIDTH'(sf);
    bus.setting_num_harmonics = NUM_HARMONICS_LOG2'(nh);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", 64'(bus.busy), 64'd1);
    i = 0;
    guard = 0;
    while (i <= last_bin && (abort_at < 0 || i < abort_at) && guard < 5000) begin
      bus.fft_valid  = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.fft_mag_in = mag_arr[i];
      bus.fft_last   = (i == last_bin) && (last_bin < NBINS - 1);
      take = bus.fft_valid && bus.fft_ready;
      @(negedge clk);
      if (take) i++;
      guard++;
    end
    bus.fft_valid = 1'b0;
    bus.fft_last  = 1'b0;
    if (guard >= 5000) begin
      check("bin_stream_timeout", 64'(i), 64'(last_bin + 1));
      return;
    end
    if (abort_at >= 0) return;
    for (int r = 0; r < NUM_HYP; r++) begin
      guard = 0;
      while (!bus.corr_valid && guard < 2000) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 2000) begin
        check("result_timeout", 64'(r), 64'(NUM_HYP));
        return;
      end
      if (r == 0 && stall > 0) begin
        snap_corr = bus.corr_out;
        snap_meta = bus.metadata_out;
        snap_idx  = bus.corr_hyp_index;
        stable = 1'b1;
        repeat (stall) begin
          @(negedge clk);
          if (!bus.corr_valid || bus.corr_out !== snap_corr || bus.metadata_out !== snap_meta ||
              bus.corr_hyp_index !== snap_idx)
            stable = 1'b0;
        end
        check("stall_hold_stable", 64'(stable), 64'd1);
      end
      bus.corr_ready = 1'b1;
      #1;
      got[r].corr = bus.corr_out;
      got[r].idx  = bus.corr_hyp_index;
      got[r].meta = bus.metadata_out;
      got[r].bv   = bus.best_valid;
      @(negedge clk);
      bus.corr_ready = 1'b0;
    end
  endtask

  // Reference model: walk the frame's bins and apply the harmonic/skirt rules
  // directly with integer arithmetic on the fixed-point spacing.
  task automatic model_frame(input int bi, input int bf, input int si, input int sf,
                             input int nh, input int last_bin);
    longint sp, m, last, h, n, d, q, best_c;
    int cnt;
    best_c = 0;
    exp_best_idx = 0;
    for (int k = 0; k < NUM_HYP; k++) begin
      sp = (longint'(bi) << SFO_FRAC_WIDTH) + longint'(bf) +
           longint'(k) * ((longint'(si) << SFO_FRAC_WIDTH) + longint'(sf));
      m = 1; last = 0; cnt = 0; n = 0; d = 0;
      for (int b = 0; b <= last_bin; b++) begin
        if (cnt < nh) begin
          h = (m * sp + (longint'(1) << (SFO_FRAC_WIDTH - 1))) >>> SFO_FRAC_WIDTH;
          if (longint'(b) == h) begin
            n += longint'(mag_arr[b]);
            cnt++;
            m++;
            last = b;
          end else if (b != 0 && longint'(b) > last + SKIRT_WIDTH && longint'(b) < h - SKIRT_WIDTH) begin
            d += longint'(mag_arr[b]);
          end
        end
      end
      q = (n << OUT_FRAC_BITS) / ((d == 0) ? 1 : d);
      if (q > (longint'(1) << CORR_WIDTH) - 1) q = (longint'(1) << CORR_WIDTH) - 1;
      exp_num[k] = n;
      exp_den[k] = d;
      exp_q.push_back(CORR_WIDTH'(q));
      if (q > best_c) begin
        best_c = q;
        exp_best_idx = k;
      end
    end
    exp_best_corr = best_c;
  endtask

  task automatic check_frame(input string tag);
    logic [CORR_WIDTH-1:0] e;
    for (int k = 0; k < NUM_HYP; k++) begin
      e = exp_q.pop_front();
      check($sformatf("%s_h%0d_corr", tag, k), 64'(got[k].corr), 64'(e));
      check($sformatf("%s_h%0d_index", tag, k), 64'(got[k].idx), 64'(k));
      check($sformatf("%s_h%0d_num", tag, k), 64'(got[k].meta[2*AW-1:AW]), 64'(exp_num[k]));
      check($sformatf("%s_h%0d_den", tag, k), 64'(got[k].meta[AW-1:0]), 64'(exp_den[k]));
      check($sformatf("%s_h%0d_best_valid", tag, k), 64'(got[k].bv), 64'(k == NUM_HYP - 1));
    end
    check({tag, "_best_index"}, 64'(bus.best_index), 64'(exp_best_idx));
    check({tag, "_best_corr"}, 64'(bus.best_corr), 64'(exp_best_corr));
    check({tag, "_idle_after"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic load_vec_expect(input int v);
    exp_num[0] = vecs[v].num0;
    exp_den[0] = vecs[v].den0;
    exp_num[1] = vecs[v].num1;
    exp_den[1] = vecs[v].den1;
    exp_q.push_back(CORR_WIDTH'(vecs[v].corr0));
    exp_q.push_back(CORR_WIDTH'(vecs[v].corr1));
    exp_best_idx  = vecs[v].best;
    exp_best_corr = (vecs[v].best == 1) ? vecs[v].corr1 : vecs[v].corr0;
  endtask

  initial begin
    int bi, bf, si, sf, nh, lb, hi;
    int saw_valid;
    // Frame table: base 8.0 / step 0.5 unless noted (frac 32768 = 0.5)
    vecs[0] = '{8, 0, 0, 32768, 3, 0, 63, 0,  8533, 69, 300, 9, 3, 11, 0};        // reference frame
    vecs[1] = '{8, 0, 0, 32768, 3, 0, 63, 20, 8533, 69, 300, 9, 3, 11, 0};        // held under back-pressure
    vecs[2] = '{8, 0, 0, 32768, 3, 1, 63, 0,  0, 0, 0, 0, 0, 0, 0};               // all-zero power
    vecs[3] = '{4, 0, 0, 32768, 5, 0, 10, 0,  25856, 512, 101, 0, 2, 0, 0};       // fft_last on bin 10
    vecs[4] = '{8, 0, 0, 32768, 3, 2, 63, 0,  1048575, 0, 196605, 0, 0, 0, 0};    // quotient saturation
    vecs[5] = '{8, 0, 0, 32768, 3, 3, 63, 0,  85, 6981, 3, 9, 300, 11, 1};        // hypothesis 1 wins
    vecs[6] = '{8, 0, 0, 32768, 0, 0, 63, 0,  0, 0, 0, 0, 0, 0, 0};               // zero harmonics

    bus.start = 1'b0;
    bus.sfo_int_base = '0; bus.sfo_frac_base = '0;
    bus.sfo_int_step = '0; bus.sfo_frac_step = '0;
    bus.setting_num_harmonics = '0;
    bus.fft_mag_in = '0; bus.fft_valid = 1'b0; bus.fft_last = 1'b0;
    bus.corr_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("post_reset");

    // Table-driven frames
    for (int v = 0; v < 7; v++) begin
      fill_pattern(vecs[v].pat);
      run_frame(vecs[v].bi, vecs[v].bf, vecs[v].si, vecs[v].sf, vecs[v].nh,
                vecs[v].last_bin, vecs[v].stall, 1'b0, -1);
      load_vec_expect(v);
      check_frame($sformatf("vec%0d", v));
    end

    // Reset at bin 30 of a frame, then a fresh frame must give the reference values
    fill_pattern(0);
    run_frame(8, 0, 0, 32768, 3, 63, 0, 1'b0, 30);
    reset = 1'b1;
    #1;
    check_reset_outputs("midframe_reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    saw_valid = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.corr_valid) saw_valid++;
    end
    check("no_result_after_reset", 64'(saw_valid), 64'd0);
    run_frame(8, 0, 0, 32768, 3, 63, 0, 1'b1, -1);
    load_vec_expect(0);
    check_frame("after_reset");

    // Start while accumulating discards the partial frame
    fill_pattern(3);
    run_frame(8, 0, 0, 32768, 3, 63, 0, 1'b0, 20);
    fill_pattern(0);
    run_frame(8, 0, 0, 32768, 3, 63, 0, 1'b0, -1);
    load_vec_expect(0);
    check_frame("after_abort");

    // Random frames against the model
    for (int t = 0; t < 10; t++) begin
      bi = $urandom_range(3, 10);
      bf = $urandom_range(0, 65535);
      si = $urandom_range(0, 2);
      sf = $urandom_range(0, 65535);
      nh = $urandom_range(0, 8);
      lb = $urandom_range(5, NBINS - 1);
      hi = (t % 3 == 0) ? 65535 : 2000;
      for (int b = 0; b < NBINS; b++) mag_arr[b] = POWER_WIDTH'($urandom_range(0, hi));
      run_frame(bi, bf, si, sf, nh, lb, $urandom_range(0, 3), 1'b1, -1);
      model_frame(bi, bf, si, sf, nh, lb);
      check_frame($sformatf("rand%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Whole-run time bound
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end
endmodule
